// File: rtl/passthrough_pkg.sv
// passthrough_pkg: shared types, defaults and helpers for the passthrough arbiter
package passthrough_pkg;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;
  localparam int DEFAULT_WIDTH = 8;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/passthrough_arbiter_rr_pick.sv
// rr_pick: first set request scanning upward from base+1, modulo NPORTS
module rr_pick
  import passthrough_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int SRCW = clog2(NPORTS)
) (
  input  logic [NPORTS-1:0] req,
  input  logic [SRCW-1:0]   base,
  output logic              found,
  output logic [SRCW-1:0]   idx
);
  logic [NPORTS-1:0] rot;
  int p;
  // rotating the doubled vector puts port base+1 at bit 0, so the wrap needs no extra logic
  always_comb begin
    rot = NPORTS'({req, req} >> (int'(base) + 1));
    found = |rot;
    idx = '0;
    p = 0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      if (rot[k]) begin
        p = int'(base) + 1 + k;
        idx = SRCW'(p >= NPORTS ? p - NPORTS : p);
      end
    end
  end
endmodule

// File: rtl/passthrough_arbiter.sv
// passthrough_arbiter: packet-locked round-robin arbiter feeding one registered output stage
module passthrough_arbiter
  import passthrough_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SRCW = clog2(NPORTS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NPORTS-1:0]       in_valid,
  output logic [NPORTS-1:0]       in_ready,
  input  logic [NPORTS*WIDTH-1:0] in_data,
  input  logic [NPORTS-1:0]       in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic [SRCW-1:0]         out_src
);
  state_e state_q, state_d;
  logic [SRCW-1:0] grant_q, grant_d, rr_last_q, rr_last_d, sel, pick_idx;
  logic [SRCW-1:0] out_src_q, out_src_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic pick_found, has, free, xfer;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;

  rr_pick #(.NPORTS(NPORTS), .SRCW(SRCW)) u_pick (
    .req(in_valid),
    .base(rr_last_q),
    .found(pick_found),
    .idx(pick_idx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_last_q <= SRCW'(NPORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_last_q <= rr_last_d;
    end
  end

  always_comb begin
    state_d = xfer ? (in_last[sel] ? IDLE : LOCKED) : state_q;
    grant_d = (xfer && !in_last[sel]) ? sel : grant_q;
    rr_last_d = (xfer && in_last[sel]) ? sel : rr_last_q;
  end

  // ready never looks at data or last, only at who owns the path and whether the stage can take a beat
  always_comb begin
    free = !out_valid_q || out_ready;
    sel = (state_q == LOCKED) ? grant_q : pick_idx;
    has = (state_q == LOCKED) || pick_found;
    in_ready = (!reset && has && free) ? NPORTS'(1) << sel : '0;
    xfer = |(in_valid & in_ready);
  end

  always_comb begin
    out_valid_d = xfer || (out_valid_q && !out_ready);
    out_data_d = xfer ? in_data[sel*WIDTH +: WIDTH] : out_data_q;
    out_last_d = xfer ? in_last[sel] : out_last_q;
    out_src_d = xfer ? sel : out_src_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_src_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_src_q <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_last = out_last_q;
  assign out_src = out_src_q;
endmodule

// File: tb/tb_passthrough_arbiter.sv
// tb_passthrough_arbiter: directed checks of arbitration, packet lock, backpressure and reset
module tb_passthrough_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int S = 2;
  logic clock = 1'b0;
  logic reset;
  logic [N-1:0] in_valid, in_ready, in_last;
  logic [N*W-1:0] in_data;
  logic out_valid, out_ready, out_last;
  logic [W-1:0] out_data;
  logic [S-1:0] out_src;
  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  passthrough_arbiter #(.NPORTS(N), .WIDTH(W), .SRCW(S)) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .out_src(out_src)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rdy(input string tag, input logic [N-1:0] exp);
    #1;
    chk(tag, 32'(in_ready), 32'(exp));
  endtask

  task automatic beat(input string tag, input int src, input logic [7:0] d, input logic l);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".src"}, 32'(out_src), 32'(src));
    chk({tag, ".data"}, 32'(out_data), 32'(d));
    chk({tag, ".last"}, 32'(out_last), 32'(l));
  endtask

  task automatic put(input int p, input logic v, input logic [7:0] d, input logic l);
    in_valid[p] = v;
    in_data[p*W +: W] = d;
    in_last[p] = l;
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b1;
    in_valid = '0;
    in_data = '0;
    in_last = '0;
    for (int i = 0; i < N; i++) put(i, 1'b1, 8'(8'h10 + i), 1'b1);
    rdy("rst_ready_pre", 4'b0000);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
    end
    reset = 1'b0;
    rdy("first_grant", 4'b0001);
    for (int k = 0; k < 6; k++) begin
      tick();
      beat("rr", k % 4, 8'(8'h10 + k % 4), 1'b1);
      rdy("rr_ready", 4'(1 << ((k + 1) % 4)));
    end
    in_valid = '0;
    tick();
    chk("rr_drain", 32'(out_valid), 32'd0);
    put(0, 1'b1, 8'h10, 1'b1);
    put(2, 1'b1, 8'hA0, 1'b0);
    rdy("lock_win", 4'b0100);
    tick();
    beat("lock0", 2, 8'hA0, 1'b0);
    put(2, 1'b1, 8'hA1, 1'b0);
    rdy("lock_block1", 4'b0100);
    tick();
    beat("lock1", 2, 8'hA1, 1'b0);
    put(2, 1'b1, 8'hA2, 1'b1);
    rdy("lock_block2", 4'b0100);
    tick();
    beat("lock2", 2, 8'hA2, 1'b1);
    put(2, 1'b0, 8'h00, 1'b0);
    rdy("unlock", 4'b0001);
    tick();
    beat("after_lock", 0, 8'h10, 1'b1);
    put(0, 1'b0, 8'h10, 1'b1);
    put(1, 1'b1, 8'h11, 1'b1);
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      rdy("bp_ready", 4'b0000);
      tick();
      beat("bp_hold", 0, 8'h10, 1'b1);
    end
    out_ready = 1'b1;
    rdy("bp_release", 4'b0010);
    tick();
    beat("bp_next", 1, 8'h11, 1'b1);
    in_valid = '0;
    tick();
    chk("bp_drain", 32'(out_valid), 32'd0);
    put(3, 1'b1, 8'h13, 1'b1);
    rdy("wrap_setup", 4'b1000);
    tick();
    beat("wrap_setup", 3, 8'h13, 1'b1);
    put(1, 1'b1, 8'h11, 1'b1);
    rdy("wrap_p1", 4'b0010);
    tick();
    beat("wrap_a", 1, 8'h11, 1'b1);
    rdy("wrap_p3", 4'b1000);
    tick();
    beat("wrap_b", 3, 8'h13, 1'b1);
    rdy("wrap_p1_again", 4'b0010);
    tick();
    beat("wrap_c", 1, 8'h11, 1'b1);
    in_valid = '0;
    put(1, 1'b1, 8'hB0, 1'b0);
    rdy("mid_win", 4'b0010);
    tick();
    beat("mid_b0", 1, 8'hB0, 1'b0);
    put(1, 1'b1, 8'hB1, 1'b0);
    reset = 1'b1;
    rdy("mid_rst_ready", 4'b0000);
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    put(0, 1'b1, 8'h20, 1'b1);
    rdy("post_rst_grant", 4'b0001);
    tick();
    beat("post_rst", 0, 8'h20, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
